// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: zero-wait-state AHB-Lite slave in front of a single-port
// 32-bit synchronous SRAM. Reads win the SRAM port in their address phase; a
// write whose data phase collides with a read is parked in a one-entry buffer
// and drained in the next cycle without a read. Reads forward buffered bytes.
//
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,    AHB address phase
//   HSIZE, HWRITE, HREADY
//   HWDATA                  AHB write data (data phase)
//   HREADYOUT, HRESP        tied ready / OKAY
//   HRDATA                  read data, valid in the read data phase, else 0
//   SRAMRDATA               SRAM read data, valid the cycle after a read strobe
//   SRAMCS, SRAMWEN,        SRAM strobe, byte write enables, word address,
//   SRAMADDR, SRAMWDATA     write data (combinational from this cycle's state)
module ahb_sram_bridge #(
  parameter int unsigned AW = 12
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [AW-1:0]   HADDR,
  input  logic [1:0]      HTRANS,
  input  logic [2:0]      HSIZE,
  input  logic            HWRITE,
  input  logic [31:0]     HWDATA,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [31:0]     HRDATA,
  input  logic [31:0]     SRAMRDATA,
  output logic            SRAMCS,
  output logic [3:0]      SRAMWEN,
  output logic [AW-3:0]   SRAMADDR,
  output logic [31:0]     SRAMWDATA
);

  localparam int unsigned WAW = AW - 2;

  logic           w_valid;
  logic           w_rd_req;
  logic           w_wr_req;
  logic [3:0]     w_be;
  logic [WAW-1:0] w_word_addr;
  logic           w_fwd;
  logic           w_unused;

  logic           r_wr_dph;
  logic [WAW-1:0] r_wr_addr;
  logic [3:0]     r_wr_be;
  logic           r_rd_dph;
  logic [WAW-1:0] r_rd_addr;
  logic           r_buf_vld;
  logic [WAW-1:0] r_buf_addr;
  logic [3:0]     r_buf_be;
  logic [31:0]    r_buf_data;

  // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
  assign w_unused    = HTRANS[0];

  assign w_valid     = HSEL & HREADY & HTRANS[1];
  assign w_rd_req    = w_valid & ~HWRITE;
  assign w_wr_req    = w_valid & HWRITE;
  assign w_word_addr = HADDR[AW-1:2];

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;

  // Byte-lane decode from size and low address bits.
  always_comb begin
    w_be = 4'b0000;
    case (HSIZE)
      3'd0:    w_be = 4'b0001 << HADDR[1:0];
      3'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Data-phase tracking and the one-entry write buffer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr_dph   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_be    <= 4'b0000;
      r_rd_dph   <= 1'b0;
      r_rd_addr  <= '0;
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_be   <= 4'b0000;
      r_buf_data <= 32'h0;
    end else begin
      r_wr_dph <= w_wr_req;
      r_rd_dph <= w_rd_req;
      if (w_wr_req) begin
        r_wr_addr <= w_word_addr;
        r_wr_be   <= w_be;
      end
      if (w_rd_req) begin
        r_rd_addr <= w_word_addr;
      end
      // A read steals the port from a write data phase: park the write.
      // Otherwise any buffered write drains on the first read-free cycle.
      if (r_wr_dph && w_rd_req) begin
        r_buf_vld  <= 1'b1;
        r_buf_addr <= r_wr_addr;
        r_buf_be   <= r_wr_be;
        r_buf_data <= HWDATA;
      end else if (!w_rd_req) begin
        r_buf_vld  <= 1'b0;
      end
    end
  end

  // A buffered write cannot coexist with a write data phase; a read in that
  // cycle would need a second buffer entry.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      assert (!(r_buf_vld && r_wr_dph && w_rd_req))
        else $error("ahb_sram_bridge: write buffer overflow");
    end
  end

  // SRAM port arbitration: read, then buffer drain, then direct write.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = '0;
    SRAMWDATA = 32'h0;
    if (!HRESET) begin
      if (w_rd_req) begin
        SRAMCS    = 1'b1;
        SRAMADDR  = w_word_addr;
      end else if (r_buf_vld) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = r_buf_be;
        SRAMADDR  = r_buf_addr;
        SRAMWDATA = r_buf_data;
      end else if (r_wr_dph) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = r_wr_be;
        SRAMADDR  = r_wr_addr;
        SRAMWDATA = HWDATA;
      end
    end
  end

  // Read data with per-byte forwarding from a not-yet-drained buffer.
  assign w_fwd = r_buf_vld & (r_buf_addr == r_rd_addr);

  always_comb begin
    HRDATA = 32'h0;
    if (!HRESET && r_rd_dph) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (w_fwd && r_buf_be[i]) ? r_buf_data[8*i +: 8]
                                                  : SRAMRDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed bench for ahb_sram_bridge with a behavioural SRAM model.
module tb_ahb_sram_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] SRAMRDATA;
  logic        SRAMCS;
  logic [3:0]  SRAMWEN;
  logic [9:0]  SRAMADDR;
  logic [31:0] SRAMWDATA;

  logic        init_mem;
  logic [31:0] mem [0:1023];
  int          sram_wr_cnt = 0;
  int          wcnt0;
  int          errors = 0;
  int          checks = 0;

  ahb_sram_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAMRDATA(SRAMRDATA), .SRAMCS(SRAMCS), .SRAMWEN(SRAMWEN),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA)
  );

  always #5 HCLK = ~HCLK;

  // SRAM model: word i initially holds 0xC0DE0000 | i.
  always @(posedge HCLK) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      SRAMRDATA <= 32'h0;
    end else if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) begin
        SRAMRDATA <= mem[SRAMADDR];
      end else begin
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
        sram_wr_cnt <= sram_wr_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic ap(input logic sel, input logic [1:0] trans, input logic wr,
                    input logic [2:0] size, input logic [11:0] addr);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HREADY = 1'b1;
  endtask

  task automatic idle;
    ap(1'b0, 2'b00, 1'b0, 3'd0, 12'h000);
  endtask

  initial begin
    HRESET   = 1'b1;
    init_mem = 1'b1;
    HWDATA   = 32'h0;
    idle();
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    init_mem = 1'b0;

    // Reset: outputs quiet even with a read presented.
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h004);
    #4;
    chk("rst_cs",    32'(SRAMCS),    32'd0);
    chk("rst_wen",   32'(SRAMWEN),   32'd0);
    chk("rst_addr",  32'(SRAMADDR),  32'd0);
    chk("rst_wdata", SRAMWDATA,      32'd0);
    chk("rst_rdata", HRDATA,         32'd0);
    chk("rst_ready", 32'(HREADYOUT), 32'd1);
    chk("rst_resp",  32'(HRESP),     32'd0);
    tick();
    HRESET = 1'b0;
    idle();
    #4;
    chk("post_rst_cs", 32'(SRAMCS), 32'd0);
    tick();

    // Word write 0x004 then read back.
    ap(1'b1, 2'b10, 1'b1, 3'd2, 12'h004);
    #4;
    chk("w4_aph_cs", 32'(SRAMCS), 32'd0);
    tick();
    idle();
    HWDATA = 32'hDEAD_BEEF;
    #4;
    chk("w4_cs",    32'(SRAMCS),   32'd1);
    chk("w4_wen",   32'(SRAMWEN),  32'hF);
    chk("w4_addr",  32'(SRAMADDR), 32'd1);
    chk("w4_wdata", SRAMWDATA,     32'hDEAD_BEEF);
    tick();
    #4;
    chk("idle_cs", 32'(SRAMCS), 32'd0);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h004);
    #4;
    chk("r4_cs",   32'(SRAMCS),   32'd1);
    chk("r4_wen",  32'(SRAMWEN),  32'd0);
    chk("r4_addr", 32'(SRAMADDR), 32'd1);
    tick();
    idle();
    #4;
    chk("r4_data", HRDATA, 32'hDEAD_BEEF);
    tick();
    #4;
    chk("r4_after", HRDATA, 32'd0);
    tick();

    // Byte write 0x003 with back-to-back read of 0x000: buffered + forwarded.
    ap(1'b1, 2'b10, 1'b1, 3'd0, 12'h003);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h000);
    HWDATA = 32'hAB00_0000;
    #4;
    chk("b3_rd_cs",   32'(SRAMCS),   32'd1);
    chk("b3_rd_wen",  32'(SRAMWEN),  32'd0);
    chk("b3_rd_addr", 32'(SRAMADDR), 32'd0);
    tick();
    idle();
    HWDATA = 32'h0;
    #4;
    chk("b3_fwd",       HRDATA,          32'hABDE_0000);
    chk("b3_drain_cs",  32'(SRAMCS),     32'd1);
    chk("b3_drain_wen", 32'(SRAMWEN),    32'b1000);
    chk("b3_drain_adr", 32'(SRAMADDR),   32'd0);
    chk("b3_drain_wd",  SRAMWDATA,       32'hAB00_0000);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h000);
    tick();
    idle();
    #4;
    chk("b3_readback", HRDATA, 32'hABDE_0000);
    tick();

    // Write 0x010 then five reads of 0x010: buffer held, one drain at end.
    ap(1'b1, 2'b10, 1'b1, 3'd2, 12'h010);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h010);
    HWDATA = 32'h1357_2468;
    #4;
    chk("r5_first_addr", 32'(SRAMADDR), 32'd4);
    wcnt0 = sram_wr_cnt;
    tick();
    HWDATA = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk("r5_fwd",  HRDATA,         32'h1357_2468);
      chk("r5_nowr", 32'(SRAMWEN),   32'd0);
      tick();
    end
    idle();
    #4;
    chk("r5_fwd_last", HRDATA,        32'h1357_2468);
    chk("r5_drain_wen", 32'(SRAMWEN), 32'hF);
    chk("r5_drain_adr", 32'(SRAMADDR), 32'd4);
    chk("r5_drain_wd", SRAMWDATA,     32'h1357_2468);
    tick();
    #4;
    chk("r5_wr_count", 32'(sram_wr_cnt - wcnt0), 32'd1);
    chk("r5_idle_cs",  32'(SRAMCS), 32'd0);
    tick();

    // Halfword write 0x022.
    ap(1'b1, 2'b10, 1'b1, 3'd1, 12'h022);
    tick();
    idle();
    HWDATA = 32'h1234_0000;
    #4;
    chk("h22_wen",  32'(SRAMWEN),  32'b1100);
    chk("h22_addr", 32'(SRAMADDR), 32'd8);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h020);
    tick();
    idle();
    #4;
    chk("h22_readback", HRDATA, 32'h1234_0008);
    tick();

    // Reset during a direct write data phase.
    ap(1'b1, 2'b10, 1'b1, 3'd2, 12'h030);
    tick();
    idle();
    HWDATA = 32'hFFFF_FFFF;
    HRESET = 1'b1;
    #4;
    chk("rw_cs",  32'(SRAMCS),  32'd0);
    chk("rw_wen", 32'(SRAMWEN), 32'd0);
    tick();
    HRESET = 1'b0;
    #4;
    chk("rw_post_cs", 32'(SRAMCS), 32'd0);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h030);
    tick();
    idle();
    #4;
    chk("rw_old_data", HRDATA, 32'hC0DE_000C);
    tick();

    // Reset while a write sits in the buffer.
    ap(1'b1, 2'b10, 1'b1, 3'd2, 12'h040);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h100);
    HWDATA = 32'h7777_7777;
    tick();
    idle();
    HRESET = 1'b1;
    #4;
    chk("rb_cs", 32'(SRAMCS), 32'd0);
    tick();
    HRESET = 1'b0;
    #4;
    chk("rb_post_cs", 32'(SRAMCS), 32'd0);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h040);
    tick();
    idle();
    #4;
    chk("rb_old_data", HRDATA, 32'hC0DE_0010);
    tick();

    // Ignored transfers: IDLE, BUSY, HREADY low, HSEL low.
    ap(1'b1, 2'b00, 1'b0, 3'd2, 12'h004);
    #4;
    chk("ign_idle_cs", 32'(SRAMCS), 32'd0);
    tick();
    ap(1'b1, 2'b01, 1'b0, 3'd2, 12'h004);
    #4;
    chk("ign_idle_rd", HRDATA,      32'd0);
    chk("ign_busy_cs", 32'(SRAMCS), 32'd0);
    tick();
    ap(1'b1, 2'b10, 1'b0, 3'd2, 12'h004);
    HREADY = 1'b0;
    #4;
    chk("ign_busy_rd",  HRDATA,      32'd0);
    chk("ign_nrdy_cs",  32'(SRAMCS), 32'd0);
    tick();
    ap(1'b0, 2'b10, 1'b0, 3'd2, 12'h004);
    #4;
    chk("ign_nrdy_rd",  HRDATA,      32'd0);
    chk("ign_nsel_cs",  32'(SRAMCS), 32'd0);
    chk("ready_tied",   32'(HREADYOUT), 32'd1);
    chk("resp_tied",    32'(HRESP),  32'd0);
    tick();
    idle();
    #4;
    chk("ign_nsel_rd", HRDATA, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_bridge.md
AHB_SRAM_BRIDGE -- requirements
Module: ahb_sram_bridge

Interface
REQ-001 SHALL have parameter AW, default 12, byte-address width; SRAM word address width is AW-2 (default 10, 1024 x 32-bit words).
REQ-002 SHALL have ports:
- HCLK  input  1  system clock; all state on rising edge
- HRESET  input  1  synchronous reset, active-high
- HSEL  input  1  slave select
- HADDR  input  AW  byte address
- HTRANS  input  2  transfer type; bit1 set = NONSEQ/SEQ
- HSIZE  input  3  transfer size
- HWRITE  input  1  1 = write
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus ready (previous transfer complete)
- HREADYOUT  output  1  slave ready
- HRESP  output  1  response
- HRDATA  output  32  read data (data phase)
- SRAMRDATA  input  32  SRAM read data, valid the cycle after a read strobe
- SRAMCS  output  1  SRAM chip select
- SRAMWEN  output  4  SRAM byte write enables, 1 = write byte
- SRAMADDR  output  AW-2  SRAM word address
- SRAMWDATA  output  32  SRAM write data
REQ-003 SHALL use one clock with synchronous, active-high reset: HCLK and HRESET.

Function
REQ-004 SHALL treat a transfer as valid when HSEL & HREADY & HTRANS[1]; rd_req = valid & ~HWRITE, wr_req = valid & HWRITE.
REQ-005 SHALL tie HREADYOUT = 1 and HRESP = 0 (OKAY); zero wait states for every transfer.
REQ-006 SHALL decode byte enables in the address phase: HSIZE=0 -> one bit at HADDR[1:0]; HSIZE=1 -> 4'b0011 or 4'b1100 by HADDR[1]; HSIZE>=2 -> 4'b1111.
REQ-007 SHALL register wr_dph, wr_addr (HADDR[AW-1:2]) and wr_be on wr_req; wr_dph marks the following cycle as a write data phase.
REQ-008 SHALL register rd_dph and rd_addr on rd_req; HRDATA is driven in the rd_dph cycle.
REQ-009 SHALL hold a one-entry write buffer (buf_vld, buf_addr, buf_be, buf_data).
REQ-010 SHALL arbitrate the SRAM port each cycle, in priority order: (1) rd_req: SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR[AW-1:2]; (2) buf_vld: SRAMCS=1, SRAMWEN=buf_be, SRAMADDR=buf_addr, SRAMWDATA=buf_data; clear buf_vld at cycle end; (3) wr_dph: SRAMCS=1, SRAMWEN=wr_be, SRAMADDR=wr_addr, SRAMWDATA=HWDATA (direct write); (4) otherwise SRAMCS=0, SRAMWEN=0.
REQ-011 SHALL, when wr_dph and rd_req coincide, load buf_addr/buf_be from wr_addr/wr_be and buf_data from HWDATA, and set buf_vld at cycle end.
REQ-012 SHALL never need two buffer entries; cases (2) and (3) of REQ-010 are mutually exclusive by construction; an assertion SHALL flag buf_vld & wr_dph & rd_req.
REQ-013 SHALL hold buf_vld across any number of consecutive rd_req cycles and drain it in the first cycle without rd_req.
REQ-014 SHALL, in a rd_dph cycle, drive HRDATA byte i = buf_data byte i when buf_vld & buf_addr==rd_addr & buf_be[i]; otherwise SRAMRDATA byte i (read-after-write forwarding).
REQ-015 SHALL drive HRDATA = 0 outside rd_dph cycles.
REQ-016 SHALL ignore transfers when HSEL=0, HREADY=0 or HTRANS is IDLE/BUSY; no SRAM access results, but the buffer still drains.
REQ-017 SHALL wrap addresses modulo 2^AW; HADDR bits above AW-1 do not exist at the port.

Reset
REQ-018 SHALL, while HRESET=1 at a rising edge, clear wr_dph, rd_dph, buf_vld, wr_be and buf_be. Reset value of every output: SRAMCS=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0, HRDATA=0, HREADYOUT=1, HRESP=0.
REQ-019 SHALL discard a buffered or in-flight write when reset is asserted mid-operation; no SRAM write is issued in or after the reset cycle.
REQ-020 SHALL drive SRAMCS=0 in the first cycle after reset deasserts unless rd_req is valid in that cycle.

Verification
REQ-021 Word write 0x004 <- 0xDEADBEEF, then idle, then read 0x004 -> data phase of the write has SRAMCS=1, SRAMWEN=4'hF, SRAMADDR=1; the read returns 0xDEADBEEF.
REQ-022 Byte write 0x003 <- HWDATA=0xAB000000, then read 0x000 at the back-to-back address phase -> buffer loaded; HRDATA[31:24]=0xAB and lower bytes come from SRAM; the buffer drains with SRAMWEN=4'b1000 in the next idle cycle.
REQ-023 Write 0x010, then 5 consecutive reads of 0x010 -> buf_vld held for all 5 reads; every read returns the forwarded data; a single SRAM write follows the last read.
REQ-024 Halfword write 0x022 <- 0x12340000 -> SRAMWEN=4'b1100, SRAMADDR=8.
REQ-025 Assert HRESET in the data phase of a write -> SRAMCS=0 in that cycle; a later read of that address returns the old contents.
REQ-026 Transfer with HSEL=1, HTRANS=IDLE or HREADY=0 -> no SRAMCS, HRDATA stays 0.
